// File: rtl/p3p_pkg.sv
// p3p_pkg: shared types and UART constants for the vector host link
package p3p_pkg;
    typedef logic signed [15:0] num;
    typedef enum logic [2:0] {IDLE, ANNOUNCE, TX_BYTE, RX_WAIT, DONE} host_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam logic UART_IDLE = 1'b1;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte receiver sampling mid-bit, rejecting start glitches
module uart_byte_rx
    import p3p_pkg::*;
#(
    parameter int clks_per_bit = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       frame_err
);
    localparam int CW = $clog2(clks_per_bit);
    localparam logic [CW-1:0] FULL = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0] HALF = CW'(clks_per_bit / 2 - 1);
    typedef enum logic [1:0] {HUNT, START, DATA, STOP} rx_state_t;
    rx_state_t r_state, w_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_sh, w_sh;
    logic          r_valid, w_valid, r_ferr, w_ferr;
    logic          w_rx;
    assign w_rx       = r_sync[1];
    assign byte_valid = r_valid;
    assign byte_out   = r_sh;
    assign frame_err  = r_ferr;
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_bit   = r_bit;
        w_sh    = r_sh;
        w_valid = 1'b0;
        w_ferr  = 1'b0;
        case (r_state)
            HUNT: begin
                w_cnt = '0;
                if (!w_rx) w_state = START;
            end
            START: if (r_cnt == HALF) begin
                w_cnt   = '0;
                w_bit   = '0;
                w_state = w_rx ? HUNT : DATA;
            end
            DATA: if (r_cnt == FULL) begin
                w_cnt = '0;
                w_sh  = {w_rx, r_sh[7:1]};
                w_bit = r_bit + 1'b1;
                if (r_bit == 3'(UART_DATA_BITS - 1)) w_state = STOP;
            end
            STOP: if (r_cnt == FULL) begin
                w_state = HUNT;
                w_valid = w_rx;
                w_ferr  = !w_rx;
            end
        endcase
        if (!enable) begin
            w_state = HUNT;
            w_valid = 1'b0;
            w_ferr  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= {2{UART_IDLE}};
            r_state <= HUNT;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_sh    <= w_sh;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
        end
    end
endmodule

// File: rtl/vector_host.sv
// vector_host: sends one framed feature vector over UART and collects the returned scores
module vector_host
    import p3p_pkg::*;
#(
    parameter int n_components = 4,
    parameter int n_senones    = 3,
    parameter int clks_per_bit = 434,
    parameter int timeout_bits = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [16*n_components-1:0] x_in,
    output logic                      idle,
    output logic                      new_vector_incoming,
    output logic                      uart_tx,
    input  logic                      uart_rx,
    output logic                      score_valid,
    output logic [7:0]                score_idx,
    output logic [15:0]               score_value,
    output logic                      vector_done,
    output logic                      timeout_err
);
    localparam int CW = $clog2(clks_per_bit);
    localparam int BW = $clog2(2 * n_components);
    localparam int SW = $clog2(n_senones);
    localparam int TW = $clog2(timeout_bits);
    localparam logic [CW-1:0] CPB_M1    = CW'(clks_per_bit - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(2 * n_components - 1);
    localparam logic [SW-1:0] LAST_SC   = SW'(n_senones - 1);
    localparam logic [TW-1:0] TO_M1     = TW'(timeout_bits - 1);
    host_state_t r_state, w_state;
    logic [CW-1:0] r_clk_cnt, w_clk_cnt;
    logic [3:0]    r_bit_cnt, w_bit_cnt;
    logic [BW-1:0] r_byte_cnt, w_byte_cnt, w_nbc;
    logic [16*n_components-1:0] r_vec, w_vec;
    logic [8:0]    r_sh, w_sh;
    logic [7:0]    w_nbyte, r_lo, w_lo, r_sidx, w_sidx, w_byte;
    logic [TW-1:0] r_to_cnt, w_to_cnt;
    logic [SW-1:0] r_sc_cnt, w_sc_cnt;
    num            r_sval, w_sval;
    logic r_tx, w_tx, r_nvi, w_nvi, r_have_lo, w_have_lo, r_idle;
    logic r_sv, w_sv, r_vd, w_vd, r_terr, w_terr;
    logic w_tick, w_rx_en, w_byte_valid, w_frame_err;
    assign w_tick  = r_clk_cnt == CPB_M1;
    assign w_nbc   = r_byte_cnt + 1'b1;
    assign w_nbyte = r_vec[{w_nbc, 3'b000} +: 8];
    assign w_rx_en = r_state == RX_WAIT;
    assign idle                = r_idle;
    assign new_vector_incoming = r_nvi;
    assign uart_tx             = r_tx;
    assign score_valid         = r_sv;
    assign score_idx           = r_sidx;
    assign score_value         = r_sval;
    assign vector_done         = r_vd;
    assign timeout_err         = r_terr;
    uart_byte_rx #(.clks_per_bit(clks_per_bit)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .enable    (w_rx_en),
        .rx        (uart_rx),
        .byte_valid(w_byte_valid),
        .byte_out  (w_byte),
        .frame_err (w_frame_err)
    );
    always_comb begin
        w_state    = r_state;
        w_clk_cnt  = w_tick ? '0 : r_clk_cnt + 1'b1;
        w_bit_cnt  = r_bit_cnt;
        w_byte_cnt = r_byte_cnt;
        w_vec      = r_vec;
        w_sh       = r_sh;
        w_tx       = r_tx;
        w_nvi      = r_nvi;
        w_to_cnt   = r_to_cnt;
        w_lo       = r_lo;
        w_have_lo  = r_have_lo;
        w_sc_cnt   = r_sc_cnt;
        w_sv       = 1'b0;
        w_sidx     = r_sidx;
        w_sval     = r_sval;
        w_vd       = 1'b0;
        w_terr     = r_terr;
        case (r_state)
            IDLE: begin
                w_clk_cnt = '0;
                if (start) begin
                    w_state   = ANNOUNCE;
                    w_vec     = x_in;
                    w_terr    = 1'b0;
                    w_nvi     = 1'b1;
                    w_to_cnt  = '0;
                    w_have_lo = 1'b0;
                    w_sc_cnt  = '0;
                end
            end
            ANNOUNCE: if (w_tick) begin
                w_state    = TX_BYTE;
                w_tx       = 1'b0;
                w_sh       = {1'b1, r_vec[7:0]};
                w_bit_cnt  = '0;
                w_byte_cnt = '0;
            end
            // r_sh carries the remaining data bits with the stop bit shifted in behind them
            TX_BYTE: if (w_tick) begin
                if (r_bit_cnt != 4'd9) begin
                    w_bit_cnt = r_bit_cnt + 1'b1;
                    w_tx      = r_sh[0];
                    w_sh      = {1'b1, r_sh[8:1]};
                end else if (r_byte_cnt != LAST_BYTE) begin
                    w_byte_cnt = w_nbc;
                    w_bit_cnt  = '0;
                    w_tx       = 1'b0;
                    w_sh       = {1'b1, w_nbyte};
                end else begin
                    w_state = RX_WAIT;
                    w_tx    = UART_IDLE;
                    w_nvi   = 1'b0;
                end
            end
            RX_WAIT: begin
                if (w_byte_valid && !w_frame_err) begin
                    w_clk_cnt = '0;
                    w_to_cnt  = '0;
                    if (!r_have_lo) begin
                        w_lo      = w_byte;
                        w_have_lo = 1'b1;
                    end else begin
                        w_have_lo = 1'b0;
                        w_sv      = 1'b1;
                        w_sval    = {w_byte, r_lo};
                        w_sidx    = 8'(r_sc_cnt);
                        w_sc_cnt  = r_sc_cnt + 1'b1;
                        if (r_sc_cnt == LAST_SC) begin
                            w_vd    = 1'b1;
                            w_state = DONE;
                        end
                    end
                end else if (w_tick) begin
                    w_to_cnt = r_to_cnt + 1'b1;
                    if (r_to_cnt == TO_M1) begin
                        w_terr    = 1'b1;
                        w_state   = DONE;
                        w_have_lo = 1'b0;
                    end
                end
            end
            DONE: w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_vec      <= '0;
            r_sh       <= '1;
            r_tx       <= UART_IDLE;
            r_nvi      <= 1'b0;
            r_to_cnt   <= '0;
            r_lo       <= '0;
            r_have_lo  <= 1'b0;
            r_sc_cnt   <= '0;
            r_idle     <= 1'b1;
            r_sv       <= 1'b0;
            r_sidx     <= '0;
            r_sval     <= '0;
            r_vd       <= 1'b0;
            r_terr     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_clk_cnt  <= w_clk_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_byte_cnt <= w_byte_cnt;
            r_vec      <= w_vec;
            r_sh       <= w_sh;
            r_tx       <= w_tx;
            r_nvi      <= w_nvi;
            r_to_cnt   <= w_to_cnt;
            r_lo       <= w_lo;
            r_have_lo  <= w_have_lo;
            r_sc_cnt   <= w_sc_cnt;
            r_idle     <= w_state == IDLE;
            r_sv       <= w_sv;
            r_sidx     <= w_sidx;
            r_sval     <= w_sval;
            r_vd       <= w_vd;
            r_terr     <= w_terr;
        end
    end
endmodule

// File: tb/tb_vector_host.sv
// tb_vector_host: table-driven vectors with tx-byte and score scoreboards
module tb_vector_host;
    localparam int CPB = 4, NC = 4, NS = 3, TO = 64;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, uart_rx = 1'b1;
    logic [63:0] x_in = '0;
    logic idle, new_vector_incoming, uart_tx, score_valid, vector_done, timeout_err;
    logic [7:0] score_idx;
    logic [15:0] score_value;
    int total = 0, bad = 0, n_done = 0, pend = 0, m_cnt = 0, d0;
    bit m_act = 0;
    logic [7:0] m_b;
    typedef struct packed {logic [7:0] idx; logic [15:0] val; logic last;} sc_t;
    typedef struct {logic [63:0] x; logic [47:0] rsp; int n;} vec_t;
    logic [7:0] q_tx[$];
    sc_t q_sc[$];
    sc_t sc_e;
    vec_t tbl[4];

    vector_host #(.n_components(NC), .n_senones(NS), .clks_per_bit(CPB), .timeout_bits(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in), .idle(idle),
        .new_vector_incoming(new_vector_incoming), .uart_tx(uart_tx), .uart_rx(uart_rx),
        .score_valid(score_valid), .score_idx(score_idx), .score_value(score_value),
        .vector_done(vector_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // decode every frame on uart_tx at mid-bit and pop the expected byte
    always @(negedge clk) begin
        if (reset) m_act = 0;
        else if (!m_act) begin
            if (uart_tx == 1'b0) begin
                m_act = 1;
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 2) check("tx_start_bit", 32'(uart_tx), 32'(0));
            if (m_cnt >= 6 && m_cnt <= 34 && (m_cnt - 6) % 4 == 0) m_b = {uart_tx, m_b[7:1]};
            if (m_cnt == 38) begin
                check("tx_stop_bit", 32'(uart_tx), 32'(1));
                if (q_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected_byte: got %0h want none", m_b);
                end else check("tx_byte", 32'(m_b), 32'(q_tx.pop_front()));
                m_act = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) pend = 0;
        else begin
            if (score_valid) begin
                if (q_sc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL score_unexpected: got idx=%0d val=%0h want none", score_idx, score_value);
                end else begin
                    sc_e = q_sc.pop_front();
                    check("score_idx", 32'(score_idx), 32'(sc_e.idx));
                    check("score_value", 32'(score_value), 32'(sc_e.val));
                    check("vector_done_with_score", 32'(vector_done), 32'(sc_e.last));
                end
            end else if (vector_done) begin
                total++;
                bad++;
                $display("FAIL vector_done_alone: got 1 want 0");
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) check("idle_2_after_done", 32'(idle), 32'(1));
            end
            if (vector_done) begin
                n_done++;
                check("idle_low_at_done", 32'(idle), 32'(0));
                pend = 2;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        tick(CPB);
    endtask

    task automatic push_tx(input logic [63:0] x);
        for (int j = 0; j < 8; j++) q_tx.push_back(x[8*j +: 8]);
    endtask

    task automatic do_start(input logic [63:0] x, input bit timing);
        int rise, low, fall, k;
        rise = -1; low = -1; fall = -1; k = 0;
        push_tx(x);
        x_in = x;
        start = 1'b1;
        while (fall < 0 && k < 2000) begin
            tick();
            k++;
            if (k == 1) begin
                start = 1'b0;
                check("idle_low_after_start", 32'(idle), 32'(0));
                check("timeout_err_cleared", 32'(timeout_err), 32'(0));
            end
            if (rise < 0 && new_vector_incoming) rise = k;
            if (low < 0 && !uart_tx) low = k;
            if (rise >= 0 && fall < 0 && !new_vector_incoming) fall = k;
        end
        check("tx_done_in_time", 32'(fall >= 0), 32'(1));
        if (timing) begin
            check("nvi_lead", 32'(low - rise), 32'(CPB));
            check("latency", 32'(fall), 32'(1 + (1 + 20 * NC) * CPB));
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!idle && k < budget) begin
            tick();
            k++;
        end
        check("reached_idle", 32'(idle), 32'(1));
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{64'h00C1_FD3C_FEDA_F6A5, 48'h8000_ABCD_1234, 6};
        tbl[1] = '{64'h7FFF_8000_FFFF_0000, 48'hFFFF_0000_7FFF, 6};
        tbl[2] = '{64'h1234_5678_9ABC_DEF0, 48'h0000_0077_5A5A, 3};
        tbl[3] = '{64'hA5A5_0F0F_F0F0_5A5A, 48'h0001_FFFE_C3C3, 6};
        tick(3);
        check("rst_idle", 32'(idle), 32'(1));
        check("rst_tx", 32'(uart_tx), 32'(1));
        check("rst_nvi", 32'(new_vector_incoming), 32'(0));
        check("rst_sv", 32'(score_valid), 32'(0));
        check("rst_idx", 32'(score_idx), 32'(0));
        check("rst_val", 32'(score_value), 32'(0));
        check("rst_vd", 32'(vector_done), 32'(0));
        check("rst_terr", 32'(timeout_err), 32'(0));
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            do_start(tbl[i].x, 1'b1);
            tick(3);
            d0 = n_done;
            for (int s = 0; s < NS; s++)
                if (2 * s + 1 < tbl[i].n) q_sc.push_back(sc_t'({8'(s), tbl[i].rsp[16*s +: 16], 1'(s == NS - 1)}));
            for (int j = 0; j < tbl[i].n; j++) send_byte(tbl[i].rsp[8*j +: 8], 1'b1);
            wait_idle(TO * CPB + 400);
            check("timeout_err", 32'(timeout_err), 32'(tbl[i].n < 2 * NS));
            check("done_count", 32'(n_done - d0), 32'(tbl[i].n == 2 * NS));
            check("score_queue_empty", 32'(q_sc.size()), 32'(0));
            check("tx_queue_empty", 32'(q_tx.size()), 32'(0));
        end
        // second start and stray rx byte during transmission must both be ignored
        fork
            do_start(64'h1111_2222_3333_4444, 1'b0);
            begin
                tick(30);
                x_in = 64'hDEAD_BEEF_0BAD_F00D;
                start = 1'b1;
                tick();
                start = 1'b0;
                tick(20);
                send_byte(8'hEE, 1'b1);
            end
        join
        tick(3);
        q_sc.push_back(sc_t'({8'd0, 16'h0102, 1'b0}));
        q_sc.push_back(sc_t'({8'd1, 16'h0304, 1'b0}));
        q_sc.push_back(sc_t'({8'd2, 16'h0506, 1'b1}));
        foreach (q_sc[j]) begin
            send_byte(q_sc[j].val[7:0], 1'b1);
            send_byte(q_sc[j].val[15:8], 1'b1);
        end
        wait_idle(TO * CPB + 400);
        check("relatch_score_queue_empty", 32'(q_sc.size()), 32'(0));
        check("relatch_tx_queue_empty", 32'(q_tx.size()), 32'(0));
        // reset in the middle of the second transmitted byte
        push_tx(64'h0F0E_0D0C_0B0A_0908);
        x_in = 64'h0F0E_0D0C_0B0A_0908;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(59);
        reset = 1'b1;
        tick();
        check("mid_rst_tx", 32'(uart_tx), 32'(1));
        check("mid_rst_nvi", 32'(new_vector_incoming), 32'(0));
        check("mid_rst_idle", 32'(idle), 32'(1));
        check("mid_rst_sv", 32'(score_valid), 32'(0));
        check("mid_rst_vd", 32'(vector_done), 32'(0));
        check("mid_rst_idx", 32'(score_idx), 32'(0));
        check("mid_rst_val", 32'(score_value), 32'(0));
        reset = 1'b0;
        q_tx.delete();
        tick(5);
        // start glitch and framing error are dropped before a valid score
        do_start(64'h0102_0304_0506_0708, 1'b0);
        tick(3);
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        tick(8);
        send_byte(8'h55, 1'b0);
        tick(4);
        q_sc.push_back(sc_t'({8'd0, 16'h0001, 1'b0}));
        q_sc.push_back(sc_t'({8'd1, 16'h0002, 1'b0}));
        q_sc.push_back(sc_t'({8'd2, 16'h0003, 1'b1}));
        foreach (q_sc[j]) begin
            send_byte(q_sc[j].val[7:0], 1'b1);
            send_byte(q_sc[j].val[15:8], 1'b1);
        end
        wait_idle(TO * CPB + 400);
        check("glitch_score_queue_empty", 32'(q_sc.size()), 32'(0));
        check("glitch_timeout_err", 32'(timeout_err), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_host.md
Name: vector_host

Overview:
- Host-side counterpart of the accelerator's data UART link. Plays the L'Imperatrice role for hardware-in-loop bring-up and regression.
- Latches one feature vector of n_components signed 16-bit numbers and frames it with new_vector_incoming.
- Transmits it over 8N1 UART, then collects the n_senones 16-bit scores the accelerator returns.
- Presents each received score as a one-cycle strobe with its index. Sits in a test top beside the accelerator, wired tx->uart_rx and rx<-uart_tx.

Parameters:
- n_components, 4, numbers per transmitted vector
- n_senones, 3, scores expected back per vector
- clks_per_bit, 434, clk cycles per UART bit (50 MHz / 115200)
- timeout_bits, 4096, bit-times of rx line silence tolerated while awaiting scores

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; latches x_in; ignored unless idle
- x_in  in  16*n_components  vector; component k at bits [16k+15:16k]
- idle  out  1  high only in IDLE
- new_vector_incoming  out  1  vector frame strobe to accelerator
- uart_tx  out  1  serial data to accelerator, idle high
- uart_rx  in  1  serial data from accelerator
- score_valid  out  1  one-cycle strobe per completed score
- score_idx  out  8  index of presented score, 0..n_senones-1
- score_value  out  16  signed score, held until next strobe
- vector_done  out  1  one-cycle strobe when all n_senones scores received
- timeout_err  out  1  sticky; cleared by reset or next accepted start

Behaviour:
- Reset values: idle=1, uart_tx=1, new_vector_incoming=0, score_valid=0, score_idx=0, score_value=0, vector_done=0, timeout_err=0. All counters cleared; FSM in IDLE. Reset mid-frame aborts at once; uart_tx returns high the next cycle.
- All outputs are registered.
- FSM states: IDLE, ANNOUNCE, TX_BYTE, RX_WAIT, DONE.
- IDLE:
  - start=1 latches x_in, clears timeout_err, and moves to ANNOUNCE.
  - start while not in IDLE has no effect.
- ANNOUNCE:
  - new_vector_incoming goes high.
  - Hold for one bit-time (clks_per_bit cycles) with uart_tx high, then go to TX_BYTE.
- TX_BYTE:
  - Send 2*n_components bytes, component 0 first, low byte first within each number.
  - Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly clks_per_bit cycles, back to back.
  - new_vector_incoming falls the cycle after the last stop bit ends; FSM then goes to RX_WAIT.
- RX_WAIT:
  - Byte receiver samples the mid-bit of start and data bits.
  - A start bit is valid only if uart_rx is still low at mid-bit; otherwise it is a glitch, return to hunting.
  - Stop bit sampled 0 (framing error): byte discarded, bit-time counting continues.
  - Bytes pair low then high into a score. On the high byte, score_value={hi,lo}, score_idx=running count, score_valid pulses one cycle.
  - On the n_senones-th score, vector_done pulses in the same cycle as score_valid; FSM goes to DONE.
  - Bytes arriving while in TX_BYTE are ignored; the receiver is enabled only in RX_WAIT.
- Timeout:
  - Counter counts bit-times in RX_WAIT and restarts on every accepted byte.
  - Reaching timeout_bits sets timeout_err and sends the FSM to DONE without vector_done; a partial low byte is dropped.
- DONE: one cycle, then IDLE. A start during DONE is ignored.
- Latency, start to last stop bit: 1 + (1 + 20*n_components)*clks_per_bit cycles.
- Counters are sized by $clog2 of their parameter. Nothing saturates; all counters are bounded by the FSM.

Decomposition:
- Package p3p_pkg:
  - typedef num (logic signed [15:0])
  - enum host_state_t {IDLE, ANNOUNCE, TX_BYTE, RX_WAIT, DONE}
  - constants UART_DATA_BITS=8, UART_IDLE=1'b1
- Sub-module uart_byte_rx (parameter clks_per_bit; ports clk, reset, enable, rx, byte_valid, byte_out, frame_err).
- Transmit shifter and FSM stay in vector_host.

Test Plan (clks_per_bit=4, n_components=4, n_senones=3, timeout_bits=64):
- Reset then start, x_in={16'h00C1,16'hFD3C,16'hFEDA,16'hF6A5} (comp3..0) -> new_vector_incoming high 4 cycles before the first start bit. Bytes on uart_tx: A5 F6 DA FE 3C FD C1 00. Strobe falls 325 cycles after start.
- Loopback model returns bytes 34 12 CD AB 00 80 -> score_valid three times with (0,16'h1234), (1,16'hABCD), (2,16'h8000). vector_done coincides with the third strobe; idle high 2 cycles later.
- Model returns only 3 bytes -> score 0 presented; after 64 silent bit-times timeout_err=1, no vector_done, idle=1. Next start clears timeout_err.
- start pulsed again during TX_BYTE with different x_in -> transmitted bytes unchanged from the first latch.
- Reset asserted mid-byte in TX_BYTE -> next cycle uart_tx=1, new_vector_incoming=0, idle=1, all strobes 0.
- 1-cycle low glitch on uart_rx in RX_WAIT, then a byte with stop bit 0, then valid bytes 01 00 -> glitch and bad byte ignored; score_valid with value 16'h0001, idx 0.
